// File: rtl/sfifo_rd_arb_pkg.sv
`default_nettype none
// =============================================================================
// Module      : sfifo_pkg
// Description : Shared types and constants for the sync-FIFO read arbiter.
// Revision    : 1.0 - initial release
// =============================================================================
package sfifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_CAP  = 2'd2
    } rd_state_e;

    localparam int REQ_CPU       = 0;
    localparam int REQ_HW        = 1;
    localparam int SFIFO_DW_DFLT = 16;

    function automatic logic [1:0] idx2onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sfifo_rd_arb_if.sv
`default_nettype none
// =============================================================================
// Module      : sfifo_rd_arb_if
// Description : Requester-side bus of the FIFO read arbiter (request/grant/data).
// Revision    : 1.0 - initial release
// =============================================================================
interface sfifo_rd_arb_if
    import sfifo_pkg::*;
#(
    parameter int DW = SFIFO_DW_DFLT
) ();

    logic [1:0]    req_i;
    logic [1:0]    gnt_o;
    logic          vld_o;
    logic [DW-1:0] dat_o;

    // slave is the arbiter, master is the requester pair
    modport slave  (input  req_i, output gnt_o, output vld_o, output dat_o);
    modport master (output req_i, input  gnt_o, input  vld_o, input  dat_o);

endinterface
`default_nettype wire

// File: rtl/sfifo_rd_arb_rr_arb2.sv
`default_nettype none
// =============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin pick; last winner remembered on latch.
// Revision    : 1.0 - initial release
// =============================================================================
module rr_arb2 (
    input  wire        wb_clk_i,
    input  wire        wb_rst_n_i,
    input  wire  [1:0] elig_i,
    input  wire        latch_i,
    output logic       any_o,
    output logic       win_o
);

    logic last_q;

    always_comb begin
        any_o = |elig_i;
        if (&elig_i) begin
            win_o = ~last_q;
        end else begin
            win_o = elig_i[1];
        end
    end

    // Reset to 1 so requester 0 takes the first tie.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            last_q <= 1'b1;
        end else if (latch_i) begin
            last_q <= win_o;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sfifo_rd_arb.sv
`default_nettype none
// =============================================================================
// Module      : sfifo_rd_arb
// Description : Sole popper of the command FIFO; arbitrates CPU vs. rate-limited HW.
// Revision    : 1.0 - initial release
// =============================================================================
module sfifo_rd_arb
    import sfifo_pkg::*;
#(
    parameter int SFIFO_DW = SFIFO_DW_DFLT,
    parameter int BP_QUOTA = 4,
    parameter int QW       = 8
) (
    input  wire                 wb_clk_i,
    input  wire                 wb_rst_n_i,
    input  wire                 bp_tick_i,
    input  wire                 sfifo_empty_i,
    input  wire  [SFIFO_DW-1:0] sfifo_di,
    output logic                sfifo_rd_o,
    output logic                busy_o,
    output logic                quota_exh_o,
    sfifo_rd_arb_if.slave       rq
);

    localparam logic [QW-1:0] QUOTA_C = QW'(BP_QUOTA);
    localparam bit            UNLIM_C = (BP_QUOTA == 0);

    rd_state_e           state_q;
    logic                win_q;
    logic                rd_q;
    logic                busy_q;
    logic                vld_q;
    logic [1:0]          gnt_q;
    logic [SFIFO_DW-1:0] dat_q;
    logic [QW-1:0]       qcnt_q;
    logic [QW-1:0]       qcnt_d;
    logic                exh_q;

    logic [1:0]          elig;
    logic                any_elig;
    logic                pick;
    logic                go;

    always_comb begin
        elig[REQ_CPU] = rq.req_i[REQ_CPU];
        elig[REQ_HW]  = rq.req_i[REQ_HW] & (UNLIM_C | (qcnt_q < QUOTA_C));
    end

    rr_arb2 u_rr (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_n_i (wb_rst_n_i),
        .elig_i     (elig),
        .latch_i    (go),
        .any_o      (any_elig),
        .win_o      (pick)
    );

    assign go = (state_q == ST_IDLE) & ~sfifo_empty_i & any_elig;

    // Tick clears first, so a same-cycle HW launch lands the count on 1.
    always_comb begin
        qcnt_d = qcnt_q;
        if (bp_tick_i) begin
            qcnt_d = '0;
        end
        if (go && (pick == 1'(REQ_HW)) && !UNLIM_C && (qcnt_d < QUOTA_C)) begin
            qcnt_d = qcnt_d + 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= ST_IDLE;
            win_q   <= 1'b0;
            rd_q    <= 1'b0;
            busy_q  <= 1'b0;
            vld_q   <= 1'b0;
            gnt_q   <= 2'b00;
            dat_q   <= '0;
            qcnt_q  <= '0;
            exh_q   <= 1'b0;
        end else begin
            qcnt_q <= qcnt_d;
            exh_q  <= !UNLIM_C && (qcnt_d >= QUOTA_C);
            vld_q  <= 1'b0;
            gnt_q  <= 2'b00;
            case (state_q)
                ST_IDLE: begin
                    if (go) begin
                        state_q <= ST_RD;
                        win_q   <= pick;
                        rd_q    <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ST_RD: begin
                    state_q <= ST_CAP;
                    rd_q    <= 1'b0;
                end
                ST_CAP: begin
                    // Delivered to the latched winner even if it has since dropped req.
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    dat_q   <= sfifo_di;
                    vld_q   <= 1'b1;
                    gnt_q   <= idx2onehot(win_q);
                end
                default: begin
                    state_q <= ST_IDLE;
                    rd_q    <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign sfifo_rd_o  = rd_q;
    assign busy_o      = busy_q;
    assign quota_exh_o = exh_q;
    assign rq.gnt_o    = gnt_q;
    assign rq.vld_o    = vld_q;
    assign rq.dat_o    = dat_q;

endmodule
`default_nettype wire
